mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store sequencer for RAM port A: issues aligned accesses as one operation,
// splits misaligned half/word accesses into byte operations and reassembles loads.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            ram_we,
    output logic [2:0]            ram_re,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]            state;
    logic [1:0]            cnt;
    logic [2:0]            nAcc;
    logic                  isWrite;
    logic                  isSigned;
    logic                  isSplit;
    logic [1:0]            size;
    logic [ADDR_WIDTH-1:0] baseAddr;
    logic [31:0]           wdata;
    logic [23:0]           asmBytes;

    logic                  reqSplit;
    logic [2:0]            reqN;
    logic                  srcWrite;
    logic                  srcSigned;
    logic                  srcSplit;
    logic [1:0]            srcSize;
    logic [ADDR_WIDTH-1:0] srcAddr;
    logic [31:0]           srcWdata;
    logic [1:0]            opIdx;
    logic [7:0]            opByte;
    logic [1:0]            opWe;
    logic [2:0]            opRe;
    logic [ADDR_WIDTH-1:0] opAddr;
    logic [31:0]           opDin;
    logic                  lastOp;
    logic [31:0]           loadResult;

    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        reqSplit = ((req_size == 2'b10) && req_addr[0]) ||
                   ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
        reqN = 3'd1;
        if (reqSplit) begin
            reqN = (req_size == 2'b11) ? 3'd4 : 3'd2;
        end
    end

    // The first operation is built from the live request so it can be registered
    // at the accept edge; later operations come from the latched copy.
    always_comb begin
        if (state == IDLE) begin
            srcWrite  = req_write;
            srcSigned = req_signed;
            srcSplit  = reqSplit;
            srcSize   = req_size;
            srcAddr   = req_addr;
            srcWdata  = req_wdata;
            opIdx     = 2'd0;
        end else begin
            srcWrite  = isWrite;
            srcSigned = isSigned;
            srcSplit  = isSplit;
            srcSize   = size;
            srcAddr   = baseAddr;
            srcWdata  = wdata;
            opIdx     = cnt + 2'd1;
        end
        opAddr = srcAddr + ADDR_WIDTH'(opIdx);
        case (opIdx)
            2'd0:    opByte = srcWdata[7:0];
            2'd1:    opByte = srcWdata[15:8];
            2'd2:    opByte = srcWdata[23:16];
            default: opByte = srcWdata[31:24];
        endcase
        if (srcSplit) begin
            opWe  = srcWrite ? 2'b01 : 2'b00;
            opRe  = srcWrite ? 3'b000 : 3'b001;
            opDin = {24'h0, opByte};
        end else begin
            opWe  = srcWrite ? srcSize : 2'b00;
            opRe  = srcWrite ? 3'b000 : {srcSigned, srcSize};
            opDin = srcWdata;
        end
        lastOp = (({1'b0, cnt} + 3'd1) == nAcc);
    end

    always_comb begin
        if (!isSplit) begin
            loadResult = ram_dout;
        end else if (nAcc == 3'd4) begin
            loadResult = {ram_dout[7:0], asmBytes};
        end else begin
            loadResult = {{16{isSigned & ram_dout[7]}}, ram_dout[7:0], asmBytes[7:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            nAcc      <= '0;
            isWrite   <= 1'b0;
            isSigned  <= 1'b0;
            isSplit   <= 1'b0;
            size      <= '0;
            baseAddr  <= '0;
            wdata     <= '0;
            asmBytes  <= '0;
            ram_we    <= '0;
            ram_re    <= '0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        isWrite  <= req_write;
                        isSigned <= req_signed;
                        isSplit  <= reqSplit;
                        size     <= req_size;
                        baseAddr <= req_addr;
                        wdata    <= req_wdata;
                        nAcc     <= reqN;
                        cnt      <= '0;
                        if (req_size == 2'b00) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state    <= ISSUE;
                            ram_we   <= opWe;
                            ram_re   <= opRe;
                            ram_addr <= opAddr;
                            if (opWe != 2'b00) begin
                                ram_din <= opDin;
                            end
                        end
                    end
                end
                ISSUE: begin
                    // Byte read at op k-1 is visible on ram_dout during op k.
                    if (isSplit && !isWrite) begin
                        case (cnt)
                            2'd1:    asmBytes[7:0]   <= ram_dout[7:0];
                            2'd2:    asmBytes[15:8]  <= ram_dout[7:0];
                            2'd3:    asmBytes[23:16] <= ram_dout[7:0];
                            default: ;
                        endcase
                    end
                    if (lastOp) begin
                        ram_we <= '0;
                        ram_re <= '0;
                        if (isWrite) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= '0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt      <= cnt + 2'd1;
                        ram_we   <= opWe;
                        ram_re   <= opRe;
                        ram_addr <= opAddr;
                        if (opWe != 2'b00) begin
                            ram_din <= opDin;
                        end
                    end
                end
                DRAIN: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= loadResult;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model, per-cycle expectation queue built from the
// access rules, plus directed literal checks and randomized requests.
module tb_mem_access_unit;
    localparam int AW = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [1:0]    ram_we;
    logic [2:0]    ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout = '0;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem    [0:32767];
    logic [7:0] refMem [0:32767];

    typedef struct {
        logic [1:0]    we;
        logic [2:0]    re;
        bit            chkAddr;
        logic [AW-1:0] addr;
        bit            chkDin;
        logic [31:0]   din;
        logic [31:0]   dinMask;
        bit            rsp;
        logic [31:0]   rdata;
        bit            err;
        int            nCommit;
        logic [AW-1:0] cAddr;
        logic [31:0]   cData;
    } expCyc_t;

    expCyc_t expQ[$];

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_we(ram_we), .ram_re(ram_re), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] extend(input logic [31:0] raw, input int nb, input bit sg);
        logic [63:0] v;
        v = {32'h0, raw};
        if (nb < 4) v = v & ((64'h1 << (8 * nb)) - 64'h1);
        if (sg && v[8 * nb - 1]) v = v | (~64'h0 << (8 * nb));
        return v[31:0];
    endfunction

    function automatic int sizeBytes(input logic [1:0] s);
        return (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 4;
    endfunction

    // RAM port A model
    always @(posedge clk) begin
        int nb;
        logic [31:0] v;
        if (ram_we != 2'b00) begin
            nb = sizeBytes(ram_we);
            for (int k = 0; k < nb; k++) mem[ram_addr + AW'(k)] = ram_din[8 * k +: 8];
        end
        if (ram_re != 3'b000) begin
            nb = sizeBytes(ram_re[1:0]);
            v = '0;
            for (int k = 0; k < nb; k++) v[8 * k +: 8] = mem[ram_addr + AW'(k)];
            ram_dout <= extend(v, nb, ram_re[2]);
        end
    end

    // Reference: on each accept, list what every following cycle must show
    always @(posedge clk) begin
        expCyc_t e;
        int nb;
        bit split;
        logic [31:0] v;
        if (!rst && req_valid && req_ready) begin
            if (req_size == 2'b00) begin
                e = '{default: '0};
                e.rsp = 1'b1; e.err = 1'b1; e.rdata = '0;
                expQ.push_back(e);
            end else begin
                nb = sizeBytes(req_size);
                split = (int'(req_addr) % nb) != 0;
                v = '0;
                for (int k = 0; k < nb; k++) v[8 * k +: 8] = refMem[req_addr + AW'(k)];
                if (!split) begin
                    e = '{default: '0};
                    e.chkAddr = 1'b1; e.addr = req_addr;
                    if (req_write) begin
                        e.we = req_size; e.chkDin = 1'b1; e.din = req_wdata;
                        e.dinMask = extend(32'hFFFFFFFF, nb, 1'b0);
                        e.nCommit = nb; e.cAddr = req_addr; e.cData = req_wdata;
                    end else begin
                        e.re = {req_signed, req_size};
                    end
                    expQ.push_back(e);
                end else begin
                    for (int k = 0; k < nb; k++) begin
                        e = '{default: '0};
                        e.chkAddr = 1'b1; e.addr = req_addr + AW'(k);
                        if (req_write) begin
                            e.we = 2'b01; e.chkDin = 1'b1; e.dinMask = 32'hFFFFFFFF;
                            e.din = {24'h0, req_wdata[8 * k +: 8]};
                            e.nCommit = 1; e.cAddr = e.addr; e.cData = e.din;
                        end else begin
                            e.re = 3'b001;
                        end
                        expQ.push_back(e);
                    end
                end
                if (!req_write) begin
                    e = '{default: '0};
                    expQ.push_back(e);
                end
                e = '{default: '0};
                e.rsp = 1'b1;
                e.rdata = req_write ? 32'h0 : extend(v, nb, req_signed);
                expQ.push_back(e);
            end
        end
    end

    // Per-cycle compare, away from the active edge
    always @(negedge clk) begin
        expCyc_t e;
        if (rst) begin
            expQ.delete();
            chk("rst_we", {30'h0, ram_we}, 32'h0);
            chk("rst_re", {29'h0, ram_re}, 32'h0);
            chk("rst_rspv", {31'h0, rsp_valid}, 32'h0);
        end else if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("cyc_we", {30'h0, ram_we}, {30'h0, e.we});
            chk("cyc_re", {29'h0, ram_re}, {29'h0, e.re});
            if (e.chkAddr) chk("cyc_addr", {17'h0, ram_addr}, {17'h0, e.addr});
            if (e.chkDin) chk("cyc_din", ram_din & e.dinMask, e.din & e.dinMask);
            chk("cyc_rspv", {31'h0, rsp_valid}, {31'h0, e.rsp});
            if (e.rsp) begin
                chk("cyc_rdata", rsp_rdata, e.rdata);
                chk("cyc_err", {31'h0, rsp_err}, {31'h0, e.err});
            end
            for (int k = 0; k < e.nCommit; k++) refMem[e.cAddr + AW'(k)] = e.cData[8 * k +: 8];
        end else begin
            chk("idle_we", {30'h0, ram_we}, 32'h0);
            chk("idle_re", {29'h0, ram_re}, 32'h0);
            chk("idle_rspv", {31'h0, rsp_valid}, 32'h0);
        end
    end

    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            errors++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
        req_signed = 1'($urandom); req_addr = AW'($urandom); req_wdata = $urandom;
        lat = 0; rd = 'x; er = 1'bx;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            errors++;
            $display("FAIL rsp_timeout actual=%0d required=<20", lat);
        end
        rd = rsp_rdata;
        er = rsp_err;
    endtask

    initial begin
        int lat;
        logic [31:0] rd;
        logic er;
        int guard;
        for (int i = 0; i < 32768; i++) begin
            mem[i] = 8'h0;
            refMem[i] = 8'h0;
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", {31'h0, req_ready}, 32'h0);
        chk("reset_addr", {17'h0, ram_addr}, 32'h0);
        chk("reset_din", ram_din, 32'h0);
        chk("reset_rdata", rsp_rdata, 32'h0);
        chk("reset_err", {31'h0, rsp_err}, 32'h0);
        #1 rst = 1'b0;
        #1 chk("ready_after_reset", {31'h0, req_ready}, 32'h1);

        doReq(1'b1, 2'b11, 1'b0, 15'h0000, 32'h78563412, lat, rd, er);
        chk("st_w0_lat", lat, 2);
        doReq(1'b0, 2'b11, 1'b0, 15'h0000, 32'h0, lat, rd, er);
        chk("ld_w0_lat", lat, 3);
        chk("ld_w0_data", rd, 32'h78563412);

        doReq(1'b1, 2'b11, 1'b0, 15'h0003, 32'hAABBCCDD, lat, rd, er);
        chk("st_w3_lat", lat, 5);
        chk("st_w3_mem6", {24'h0, mem[6]}, 32'hAA);
        doReq(1'b0, 2'b11, 1'b0, 15'h0003, 32'h0, lat, rd, er);
        chk("ld_w3_lat", lat, 6);
        chk("ld_w3_data", rd, 32'hAABBCCDD);

        doReq(1'b1, 2'b11, 1'b0, 15'h0008, 32'hFFFEFDFC, lat, rd, er);
        doReq(1'b0, 2'b10, 1'b1, 15'h0009, 32'h0, lat, rd, er);
        chk("ld_hs9_lat", lat, 4);
        chk("ld_hs9_data", rd, 32'hFFFFFEFD);
        doReq(1'b0, 2'b10, 1'b0, 15'h0009, 32'h0, lat, rd, er);
        chk("ld_hu9_data", rd, 32'h0000FEFD);
        doReq(1'b0, 2'b01, 1'b1, 15'h000B, 32'h0, lat, rd, er);
        chk("ld_bs11_data", rd, 32'hFFFFFFFF);
        doReq(1'b0, 2'b10, 1'b1, 15'h0008, 32'h0, lat, rd, er);
        chk("ld_hs8_lat", lat, 3);
        chk("ld_hs8_data", rd, 32'hFFFFFDFC);

        doReq(1'b0, 2'b00, 1'b1, 15'h0005, 32'h0, lat, rd, er);
        chk("illegal_lat", lat, 1);
        chk("illegal_err", {31'h0, er}, 32'h1);
        chk("illegal_rdata", rd, 32'h0);

        // Reset during the third byte write of a split store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_signed = 1'b0;
        req_addr = 15'h0021; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_we", {30'h0, ram_we}, 32'h0);
        chk("midrst_rspv", {31'h0, rsp_valid}, 32'h0);
        chk("midrst_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("midrst_ready_after", {31'h0, req_ready}, 32'h1);
        chk("midrst_m21", {24'h0, mem[15'h21]}, 32'h44);
        chk("midrst_m22", {24'h0, mem[15'h22]}, 32'h33);
        chk("midrst_m23", {24'h0, mem[15'h23]}, 32'h00);
        chk("midrst_m24", {24'h0, mem[15'h24]}, 32'h00);

        doReq(1'b0, 2'b11, 1'b0, 15'h7FFE, 32'h0, lat, rd, er);
        chk("wrap_lat", lat, 6);
        chk("wrap_data", rd, 32'h34120000);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b11; req_signed = 1'b0;
        req_addr = 15'h0008; req_wdata = '0;
        @(posedge clk);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid && guard < 20);
        chk("b2b_first_data", rsp_rdata, 32'hFFFEFDFC);
        @(negedge clk);
        chk("b2b_ready_idle", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("b2b_accepted", {31'h0, req_ready}, 32'h0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!rsp_valid && guard < 20);
        chk("b2b_second_lat", guard, 3);
        chk("b2b_second_data", rsp_rdata, 32'hFFFEFDFC);

        for (int i = 0; i < 80; i++) begin
            logic [AW-1:0] a;
            a = ($urandom % 2 == 0) ? AW'($urandom_range(0, 40)) : AW'(15'h7FF0 + $urandom_range(0, 15));
            doReq(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, lat, rd, er);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
